// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage data-memory access FSM; optional alignment trap via MEM_MISALIGN_TRAP_EN
module mem_access_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic [63:0] ex_address,
    input  logic [63:0] ex_storeData,
    input  logic        ex_MemRead,
    input  logic        ex_MemWrite,
    input  logic [1:0]  ex_size,
    input  logic [4:0]  ex_Rd,
    input  logic [1:0]  ex_MemToReg,
    input  logic        ex_RegWrite,
    input  logic        ex_ChooseRd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [63:0] memData,
    output logic [63:0] address,
    output logic [4:0]  Rd,
    output logic [1:0]  MemToReg,
    output logic        RegWrite,
    output logic        ChooseRd,
    output logic        stall,
    output logic        misalign
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state, state_nx;
    logic [63:0] l_addr, l_wdata, l_rdata;
    logic [1:0]  l_size, l_memtoreg;
    logic [4:0]  l_rd;
    logic        l_we, l_regwrite, l_chooserd;
    logic        mem_op, bad_align, accept;
    logic [63:0] ext_data;

    assign mem_op = ex_valid & (ex_MemRead | ex_MemWrite);

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        bad_align = 1'b0;
        case (ex_size)
            2'd1:    bad_align = ex_address[0];
            2'd2:    bad_align = |ex_address[1:0];
            2'd3:    bad_align = |ex_address[2:0];
            default: bad_align = 1'b0;
        endcase
    end
`else
    assign bad_align = 1'b0;
`endif

    assign accept = (state == IDLE) & mem_op & ~bad_align;

    // Request-side outputs come straight from the latches so they hold between ops.
    assign mem_we    = l_we;
    assign mem_addr  = l_addr;
    assign mem_wdata = l_wdata;
    assign mem_size  = l_size;

    always_comb begin
        ext_data = 64'd0;
        case (l_size)
            2'd0:    ext_data = {56'd0, l_rdata[7:0]};
            2'd1:    ext_data = {48'd0, l_rdata[15:0]};
            2'd2:    ext_data = {32'd0, l_rdata[31:0]};
            default: ext_data = l_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            l_addr     <= 64'd0;
            l_wdata    <= 64'd0;
            l_rdata    <= 64'd0;
            l_size     <= 2'd0;
            l_memtoreg <= 2'd0;
            l_rd       <= 5'd0;
            l_we       <= 1'b0;
            l_regwrite <= 1'b0;
            l_chooserd <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                l_addr     <= ex_address;
                l_wdata    <= ex_storeData;
                l_size     <= ex_size;
                l_memtoreg <= ex_MemToReg;
                l_rd       <= ex_Rd;
                l_we       <= ex_MemWrite;
                l_regwrite <= ex_RegWrite;
                l_chooserd <= ex_ChooseRd;
            end
            if (state == REQ && mem_ack) begin
                l_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        mem_req  = 1'b0;
        misalign = 1'b0;
        address  = ex_address;
        Rd       = ex_Rd;
        MemToReg = ex_MemToReg;
        ChooseRd = ex_ChooseRd;
        RegWrite = 1'b0;
        memData  = 64'd0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    if (bad_align) begin
                        misalign = ~reset;
                    end else begin
                        stall    = 1'b1;
                        state_nx = REQ;
                    end
                end else begin
                    RegWrite = ex_valid & ex_RegWrite;
                end
            end
            REQ: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                address  = l_addr;
                Rd       = l_rd;
                MemToReg = l_memtoreg;
                ChooseRd = l_chooserd;
                if (mem_ack) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                address  = l_addr;
                Rd       = l_rd;
                MemToReg = l_memtoreg;
                ChooseRd = l_chooserd;
                RegWrite = l_regwrite & ~l_we;
                memData  = l_we ? 64'd0 : ext_data;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - directed scoreboard bench for mem_access_stage
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [63:0] ex_address, ex_storeData;
    logic        ex_MemRead, ex_MemWrite;
    logic [1:0]  ex_size;
    logic [4:0]  ex_Rd;
    logic [1:0]  ex_MemToReg;
    logic        ex_RegWrite, ex_ChooseRd;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic [63:0] memData, address;
    logic [4:0]  Rd;
    logic [1:0]  MemToReg;
    logic        RegWrite, ChooseRd, stall, misalign;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] mdata;
        logic [63:0] addr;
        logic [4:0]  rd;
        logic [1:0]  memtoreg;
        logic        chooserd;
        logic        rw;
        int          stalls;
        int          reqs;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_stage dut (
        .clk(clk), .reset(reset), .ex_valid(ex_valid), .ex_address(ex_address),
        .ex_storeData(ex_storeData), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_size(ex_size), .ex_Rd(ex_Rd), .ex_MemToReg(ex_MemToReg), .ex_RegWrite(ex_RegWrite),
        .ex_ChooseRd(ex_ChooseRd), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .memData(memData), .address(address), .Rd(Rd), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .ChooseRd(ChooseRd), .stall(stall), .misalign(misalign)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the rising edge that leaves the op.
    task automatic run_op(input string tag, input logic rd_op, input logic wr_op,
                          input logic [63:0] addr, input logic [63:0] sdata, input logic [1:0] size,
                          input logic [4:0] rd, input logic rw, input logic [63:0] rdata,
                          input int ack_delay, input logic [63:0] exp_mdata);
        exp_t e;
        int   reqs = 0;
        int   stalls = 0;
        int   n = 0;
        bit   done = 0;
        ex_valid     = 1'b1;
        ex_MemRead   = rd_op;
        ex_MemWrite  = wr_op;
        ex_address   = addr;
        ex_storeData = sdata;
        ex_size      = size;
        ex_Rd        = rd;
        ex_MemToReg  = size;
        ex_RegWrite  = rw;
        ex_ChooseRd  = rd[0];
        e.mdata    = exp_mdata;
        e.addr     = addr;
        e.rd       = rd;
        e.memtoreg = size;
        e.chooserd = rd[0];
        e.rw       = wr_op ? 1'b0 : rw;
        e.stalls   = (rd_op || wr_op) ? 2 + ack_delay : 0;
        e.reqs     = (rd_op || wr_op) ? 1 + ack_delay : 0;
        sb.push_back(e);
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (mem_req) begin
                if (reqs == 0) begin
                    chk({tag, "_mem_we"}, mem_we, wr_op);
                    chk({tag, "_mem_addr"}, mem_addr, addr);
                    chk({tag, "_mem_size"}, mem_size, size);
                    if (wr_op) chk({tag, "_mem_wdata"}, mem_wdata, sdata);
                end
                if (reqs == ack_delay) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                reqs++;
            end else begin
                mem_ack = 1'b0;
            end
            if (stall) stalls++;
            else done = 1;
        end
        if (!done) chk({tag, "_timeout"}, 64'd0, 64'd1);
        e = sb.pop_front();
        chk({tag, "_memData"}, memData, e.mdata);
        chk({tag, "_address"}, address, e.addr);
        chk({tag, "_Rd"}, Rd, e.rd);
        chk({tag, "_MemToReg"}, MemToReg, e.memtoreg);
        chk({tag, "_ChooseRd"}, ChooseRd, e.chooserd);
        chk({tag, "_RegWrite"}, RegWrite, e.rw);
        chk({tag, "_stall_cycles"}, stalls, e.stalls);
        chk({tag, "_req_cycles"}, reqs, e.reqs);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; ex_valid = 1'b0; ex_address = 64'd0; ex_storeData = 64'd0;
        ex_MemRead = 1'b0; ex_MemWrite = 1'b0; ex_size = 2'd0; ex_Rd = 5'd0;
        ex_MemToReg = 2'd0; ex_RegWrite = 1'b0; ex_ChooseRd = 1'b0;
        mem_ack = 1'b0; mem_rdata = 64'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_misalign", misalign, 1'b0);
        chk("rst_memData", memData, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        ex_address = 64'h55; ex_Rd = 5'd7; ex_RegWrite = 1'b1;
        @(negedge clk);
        chk("bubble_address", address, 64'h55);
        chk("bubble_Rd", Rd, 5'd7);
        chk("bubble_RegWrite", RegWrite, 1'b0);
        chk("bubble_stall", stall, 1'b0);
        @(posedge clk);
        #1;

        run_op("alu0", 0, 0, 64'hABC, 64'd0, 2'd3, 5'd3, 1, 64'd0, 0, 64'd0);
        run_op("ld_dword", 1, 0, 64'h100, 64'd0, 2'd3, 5'd5, 1, 64'hDEADBEEF_CAFEF00D, 2, 64'hDEADBEEF_CAFEF00D);
        run_op("ld_byte", 1, 0, 64'h203, 64'd0, 2'd0, 5'd6, 1, 64'hFFFF_FFFF_FFFF_FF85, 0, 64'h85);
        run_op("ld_half", 1, 0, 64'h10, 64'd0, 2'd1, 5'd8, 1, 64'h1111_2222_8765_4321, 1, 64'h4321);
        run_op("ld_word", 1, 0, 64'h20, 64'd0, 2'd2, 5'd9, 1, 64'h1111_2222_8765_4321, 0, 64'h8765_4321);
        run_op("st", 0, 1, 64'h40, 64'h1234, 2'd3, 5'd10, 1, 64'hFFFF, 0, 64'd0);
        ex_valid = 1'b0;
        @(negedge clk);
        chk("hold_mem_req", mem_req, 1'b0);
        chk("hold_mem_we", mem_we, 1'b1);
        chk("hold_mem_addr", mem_addr, 64'h40);
        chk("hold_mem_wdata", mem_wdata, 64'h1234);
        @(posedge clk);
        #1;

        run_op("b2b_alu", 0, 0, 64'h77, 64'd0, 2'd0, 5'd11, 1, 64'd0, 0, 64'd0);
        run_op("b2b_ld1", 1, 0, 64'h500, 64'd0, 2'd3, 5'd12, 1, 64'h0123_4567_89AB_CDEF, 0, 64'h0123_4567_89AB_CDEF);
        run_op("b2b_ld2", 1, 0, 64'h508, 64'd0, 2'd3, 5'd13, 1, 64'hFEDC_BA98_7654_3210, 1, 64'hFEDC_BA98_7654_3210);

`ifdef MEM_MISALIGN_TRAP_EN
        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0;
        ex_address = 64'h102; ex_size = 2'd2; ex_RegWrite = 1'b1;
        @(negedge clk);
        chk("mis_flag", misalign, 1'b1);
        chk("mis_mem_req", mem_req, 1'b0);
        chk("mis_stall", stall, 1'b0);
        chk("mis_RegWrite", RegWrite, 1'b0);
        @(posedge clk);
        #1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("mis_after_req", mem_req, 1'b0);
        chk("mis_after_flag", misalign, 1'b0);
        @(posedge clk);
        #1;
`else
        run_op("mis_ld_word", 1, 0, 64'h102, 64'd0, 2'd2, 5'd14, 1, 64'hAAAA_BBBB_CCCC_DDDD, 0, 64'hCCCC_DDDD);
        chk("nomis_flag", misalign, 1'b0);
`endif

        ex_valid = 1'b1; ex_MemRead = 1'b1; ex_MemWrite = 1'b0;
        ex_address = 64'h300; ex_size = 2'd3; ex_Rd = 5'd9; ex_RegWrite = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst1_req_issued", mem_req, 1'b1);
        reset = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("rst1_mem_req", mem_req, 1'b0);
        chk("rst1_mem_addr", mem_addr, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mem_ack = 1'b1;
        mem_rdata = 64'hBAD0_BAD0;
        @(negedge clk);
        chk("rst1_late_ack_stall", stall, 1'b0);
        chk("rst1_late_ack_memData", memData, 64'd0);
        chk("rst1_late_ack_req", mem_req, 1'b0);
        mem_ack = 1'b0;
        @(posedge clk);
        #1;

        ex_valid = 1'b1; ex_address = 64'h308;
        @(negedge clk);
        @(negedge clk);
        chk("rst2_req_issued", mem_req, 1'b1);
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_rdata = 64'h1357_9BDF;
        ex_valid = 1'b0;
        @(negedge clk);
        chk("rst2_mem_req", mem_req, 1'b0);
        chk("rst2_memData", memData, 64'd0);
        reset = 1'b0;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rst2_no_done_memData", memData, 64'd0);
        chk("rst2_no_done_RegWrite", RegWrite, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high; sampled on rising edge of clk.
REQ-003 ex_valid  in  1  EX/MEM register holds a live instruction.
REQ-004 ex_address  in  64  ALU result; memory address, or pass-through result for non-memory ops.
REQ-005 ex_storeData  in  64  store data (Rt value).
REQ-006 ex_MemRead, ex_MemWrite  in  1 each  load / store; never both high.
REQ-007 ex_size  in  2  transfer size: 0 byte, 1 half, 2 word, 3 dword.
REQ-008 ex_Rd  in  5; ex_MemToReg  in  2; ex_RegWrite  in  1; ex_ChooseRd  in  1  control passed toward MEM/WB.
REQ-009 mem_req  out  1; mem_we  out  1; mem_addr  out  64; mem_wdata  out  64; mem_size  out  2  data-memory request.
REQ-010 mem_ack  in  1; mem_rdata  in  64  data-memory completion and read data.
REQ-011 memData, address  out  64 each; Rd  out  5; MemToReg  out  2; RegWrite  out  1; ChooseRd  out  1  feed MEM/WB register.
REQ-012 stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM while high.
REQ-013 misalign  out  1  misaligned-access flag (Configuration only; tied 0 otherwise).

Function
REQ-014 FSM states: IDLE, REQ, DONE; encoding free.
REQ-015 IDLE, ex_valid=0: outputs = ex_* pass-through with RegWrite=0, memData=0, stall=0.
REQ-016 IDLE, ex_valid=1, no memory op: address=ex_address, control pass-through, memData=0, stall=0, same cycle.
REQ-017 IDLE, ex_valid=1 and MemRead or MemWrite: stall=1 combinationally; next edge latch address, storeData, size, Rd, control; go to REQ.
REQ-018 REQ: mem_req=1, mem_we=latched MemWrite, mem_addr/mem_wdata/mem_size from latches; stall=1; hold until mem_ack=1.
REQ-019 mem_ack sampled only while mem_req=1; ack outside REQ ignored.
REQ-020 REQ with mem_ack=1: capture mem_rdata, go to DONE; minimum load/store latency 2 cycles from IDLE detection to DONE.
REQ-021 Load data zero-extended per size: byte keeps [7:0], half [15:0], word [31:0], dword all 64; upper bits 0.
REQ-022 DONE: outputs from latches, memData=extended load data (0 for store), stall=0 for exactly one cycle; next edge to IDLE.
REQ-023 Store: RegWrite output forced 0 regardless of ex_RegWrite.
REQ-024 In IDLE/DONE mem_req=0; mem_we, mem_addr, mem_wdata, mem_size hold last values.
REQ-025 Back-to-back memory ops: DONE of op N followed by IDLE detection of op N+1; no request dropped, no duplicate request.

Reset
REQ-026 reset=1: next state IDLE; mem_req=0, mem_we=0, latches cleared to 0, misalign=0.
REQ-027 Reset mid-REQ abandons transaction; mem_req low from the same edge; later mem_ack ignored.
REQ-028 Reset has priority over every other event incl. simultaneous mem_ack.

Configuration
REQ-029 Macro MEM_MISALIGN_TRAP_EN.
REQ-030 Defined: memory op whose address is not size-aligned (half: addr[0]; word: addr[1:0]; dword: addr[2:0] nonzero) sets misalign=1 for one cycle in IDLE, issues no mem_req, forces RegWrite=0, stall=0, stays IDLE.
REQ-031 Not defined: no alignment check; misalign tied 0; misaligned ops issued as normal.

Verification
REQ-032 Reset mid-REQ: load issued, reset asserted before ack -> mem_req=0 next cycle, state IDLE, ack 2 cycles later produces no DONE.
REQ-033 Dword load addr 0x100, ack after 3 cycles, rdata 0xDEADBEEF_CAFEF00D -> stall high 4 cycles, DONE memData 0xDEADBEEF_CAFEF00D, Rd/RegWrite from latch.
REQ-034 Byte load, rdata 0xFFFF_FFFF_FFFF_FF85 -> memData 0x85.
REQ-035 Store addr 0x40 data 0x1234, ex_RegWrite=1, ack same cycle as req -> mem_we=1, mem_wdata 0x1234, RegWrite=0, memData=0.
REQ-036 ALU op then two back-to-back loads -> ALU op 0-cycle stall, two distinct mem_req pulses, two DONE cycles in order.
REQ-037 With MEM_MISALIGN_TRAP_EN: word load addr 0x102 -> misalign=1, mem_req stays 0; without: mem_req=1, mem_addr 0x102.
